// File: rtl/countdown_timer_if.sv
// Key-pulse / display bundle between a controller (or bench) and countdown_timer.
// Master drives the key pulses and preset; slave returns BCD digits and status.
interface countdown_timer_if;
    logic        load;
    logic        start_pause;
    logic [23:0] preset;
    logic [23:0] digits;
    logic        running;
    logic        paused;
    logic        alarm;

    modport master (
        output load, start_pause, preset,
        input  digits, running, paused, alarm
    );

    modport slave (
        input  load, start_pause, preset,
        output digits, running, paused, alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// mm:ss.cc BCD countdown timer with alarm on expiry.
// Build option: define ALARM_BLINK_EN to make the alarm blink every BLINK_TICKS ticks.
module countdown_timer #(
    parameter int COUNTS      = 500000,
    parameter int BLINK_TICKS = 25
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);
    localparam int CW = $clog2(COUNTS);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic          wrap;
    logic [23:0]   preset_c;
    logic [23:0]   digits_dec;

`ifdef ALARM_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    logic [BW-1:0] blink_cnt;
`endif

    // Digit index 0 is cs_l; indices 3 (sec_h) and 5 (min_h) are base-6 digits.
    function automatic logic [3:0] digit_max(input int i);
        return (i == 3 || i == 5) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [23:0] bcd_clamp(input logic [23:0] d);
        logic [23:0] r;
        r = d;
        for (int i = 0; i < 6; i++)
            if (r[i*4 +: 4] > digit_max(i)) r[i*4 +: 4] = digit_max(i);
        return r;
    endfunction

    function automatic logic [23:0] bcd_dec(input logic [23:0] d);
        logic [23:0] r;
        logic        borrow;
        r      = d;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = digit_max(i);
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign wrap       = (tick_cnt == CW'(COUNTS - 1));
    assign preset_c   = bcd_clamp(bus.preset);
    assign digits_dec = bcd_dec(bus.digits);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.digits  <= '0;
            tick_cnt    <= '0;
            bus.running <= 1'b0;
            bus.paused  <= 1'b0;
            bus.alarm   <= 1'b0;
`ifdef ALARM_BLINK_EN
            blink_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        bus.digits <= preset_c;
                        tick_cnt   <= '0;
                    end else if (bus.start_pause && bus.digits != '0) begin
                        state       <= RUN;
                        bus.running <= 1'b1;
                    end
                end
                RUN: begin
                    tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
                    if (wrap) bus.digits <= digits_dec;
                    // Expiry outranks a pause requested on the same edge.
                    if (wrap && bus.digits == 24'h000001) begin
                        state       <= EXPIRED;
                        bus.running <= 1'b0;
                        bus.alarm   <= 1'b1;
`ifdef ALARM_BLINK_EN
                        blink_cnt   <= '0;
`endif
                    end else if (bus.start_pause) begin
                        state       <= PAUSE;
                        bus.running <= 1'b0;
                        bus.paused  <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (bus.load) begin
                        bus.digits <= preset_c;
                        tick_cnt   <= '0;
                        state      <= IDLE;
                        bus.paused <= 1'b0;
                    end else if (bus.start_pause) begin
                        state       <= RUN;
                        bus.running <= 1'b1;
                        bus.paused  <= 1'b0;
                    end
                end
                EXPIRED: begin
                    if (bus.load || bus.start_pause) begin
                        if (bus.load) bus.digits <= preset_c;
                        tick_cnt  <= '0;
                        state     <= IDLE;
                        bus.alarm <= 1'b0;
                    end
`ifdef ALARM_BLINK_EN
                    else begin
                        tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
                        if (wrap) begin
                            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                                blink_cnt <= '0;
                                bus.alarm <= ~bus.alarm;
                            end else begin
                                blink_cnt <= blink_cnt + 1'b1;
                            end
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: integer-centisecond reference model checked every cycle,
// directed literal checks for the documented scenarios, then randomized key pulses.
module tb_countdown_timer;
    localparam int COUNTS      = 4;
    localparam int BLINK_TICKS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    countdown_timer_if bus ();

    countdown_timer #(.COUNTS(COUNTS), .BLINK_TICKS(BLINK_TICKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time kept as plain centiseconds.
    int m_mode = 0;   // 0 idle, 1 run, 2 pause, 3 expired
    int m_t = 0;
    int m_cnt = 0;
    int m_blink = 0;
    bit m_alarm = 1'b0;

    function automatic int preset_to_cs(input logic [23:0] p);
        int d[6];
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(p[i*4 +: 4]);
            if ((i == 3 || i == 5) && d[i] > 5) d[i] = 5;
            else if (d[i] > 9) d[i] = 9;
        end
        return ((d[5] * 10 + d[4]) * 60 + d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
    endfunction

    function automatic logic [23:0] cs_to_bcd(input int t);
        int mm, ss, cc;
        mm = t / 6000;
        ss = (t / 100) % 60;
        cc = t % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_t = 0; m_cnt = 0; m_alarm = 0; m_blink = 0;
        end else begin
            case (m_mode)
                0: if (bus.load) begin
                       m_t = preset_to_cs(bus.preset); m_cnt = 0;
                   end else if (bus.start_pause && m_t != 0) m_mode = 1;
                1: begin
                       m_cnt++;
                       if (m_cnt == COUNTS) begin
                           m_cnt = 0;
                           m_t--;
                           if (m_t == 0) begin
                               m_mode = 3; m_alarm = 1; m_blink = 0;
                           end
                       end
                       if (m_mode == 1 && bus.start_pause) m_mode = 2;
                   end
                2: if (bus.load) begin
                       m_t = preset_to_cs(bus.preset); m_cnt = 0; m_mode = 0;
                   end else if (bus.start_pause) m_mode = 1;
                default: if (bus.load || bus.start_pause) begin
                       if (bus.load) m_t = preset_to_cs(bus.preset);
                       m_cnt = 0; m_mode = 0; m_alarm = 0;
                   end else begin
`ifdef ALARM_BLINK_EN
                       m_cnt++;
                       if (m_cnt == COUNTS) begin
                           m_cnt = 0;
                           m_blink++;
                           if (m_blink == BLINK_TICKS) begin
                               m_blink = 0; m_alarm = !m_alarm;
                           end
                       end
`endif
                   end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [26:0] exp_v, act_v;
            exp_v = {cs_to_bcd(m_t), m_mode == 1, m_mode == 2, m_alarm};
            act_v = {bus.digits, bus.running, bus.paused, bus.alarm};
            tests++;
            if (exp_v !== act_v) begin
                fails++;
                $display("FAIL model_cmp t=%0t digits/run/pause/alarm got %h %b%b%b exp %h %b%b%b",
                         $time, act_v[26:3], act_v[2], act_v[1], act_v[0],
                         exp_v[26:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic l, input logic s);
        bus.load = l; bus.start_pause = s;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.start_pause = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] p;
        bit blink_exp[5];
        bus.load = 1'b0; bus.start_pause = 1'b0; bus.preset = '0;
`ifdef ALARM_BLINK_EN
        blink_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        blink_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_out", {bus.digits, bus.running, bus.paused, bus.alarm}, 32'h0);

        // 00:00.03 down to expiry
        bus.preset = 24'h000003;
        pulse(1, 0);
        pulse(0, 1);
        check("start_running", bus.running, 1);
        wait_cyc(4); check("cd_02", bus.digits, 24'h000002);
        wait_cyc(4); check("cd_01", bus.digits, 24'h000001);
        wait_cyc(4); check("cd_00", bus.digits, 24'h000000);
        check("exp_alarm_run", {bus.alarm, bus.running}, 2'b10);
        for (int k = 1; k < 5; k++) begin
            wait_cyc(4);
            check($sformatf("alarm_blk%0d", k), bus.alarm, blink_exp[k]);
        end
        pulse(0, 1);
        check("exp_clear", {bus.alarm, bus.running, bus.paused}, 3'b000);

        // full borrow chain, clamping
        bus.preset = 24'h010000;
        pulse(1, 0); pulse(0, 1);
        wait_cyc(4); check("borrow_chain", bus.digits, 24'h005999);
        pulse(0, 1);
        check("paused_flag", {bus.running, bus.paused}, 2'b01);
        bus.preset = 24'h9F7ABC;
        pulse(1, 0);
        check("clamp_load", bus.digits, 24'h595999);
        pulse(0, 1);
        wait_cyc(4); check("clamp_dec", bus.digits, 24'h595998);

        // pause preserves partial period; load during RUN ignored
        pulse(0, 1);
        bus.preset = 24'h000005;
        pulse(1, 0); check("load5", bus.digits, 24'h000005);
        pulse(0, 1);
        wait_cyc(5);
        pulse(0, 1);
        check("pause6", {bus.digits, bus.paused}, {24'h000004, 1'b1});
        wait_cyc(20); check("pause_hold", bus.digits, 24'h000004);
        pulse(0, 1);
        wait_cyc(1); check("resume_1", bus.digits, 24'h000004);
        wait_cyc(1); check("resume_2", bus.digits, 24'h000003);
        bus.preset = 24'h000099;
        pulse(1, 0);
        check("load_in_run", {bus.digits, bus.running}, {24'h000003, 1'b1});
        wait_cyc(11);
        check("expire2", {bus.digits, bus.alarm}, {24'h000000, 1'b1});

        // load wins over start_pause; start with zero ignored
        bus.preset = 24'h000042;
        pulse(1, 0);
        bus.preset = 24'h000077;
        pulse(1, 1);
        check("load_wins", {bus.digits, bus.running}, {24'h000077, 1'b0});
        wait_cyc(4); check("load_wins_idle", {bus.digits, bus.running}, {24'h000077, 1'b0});
        bus.preset = 24'h000000;
        pulse(1, 0); pulse(0, 1);
        check("start_zero", bus.running, 0);

        // reset mid-run
        bus.preset = 24'h000050;
        pulse(1, 0); pulse(0, 1);
        wait_cyc(5);
        rst = 1'b1; wait_cyc(1); rst = 1'b0;
        check("rst_midrun", {bus.digits, bus.running, bus.paused, bus.alarm}, 32'h0);

        // randomized key pulses checked by the model every cycle
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 7) == 0) p = 24'($urandom);
            else p = {12'h000, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            bus.preset      = p;
            bus.load        = ($urandom_range(0, 15) == 0);
            bus.start_pause = ($urandom_range(0, 11) == 0);
            rst             = ($urandom_range(0, 599) == 0);
            @(posedge clk); #1;
        end
        bus.load = 1'b0; bus.start_pause = 1'b0; rst = 1'b0;
        wait_cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
